pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline. Merges stall requests from ID (load-use),
//  EX (multi-cycle op) and MEM (memory wait) into one per-stage stall vector.
//  Sequences branch/exception flushes, including requests that arrive while MEM is stalled.
//  Also runs a stall watchdog and a saturating stall-cycle performance counter.
// PARAMETERS
//  ADDR_W        32    width of PC / flush target
//  FLUSH_CYCLES  1     cycles o_flush is held per flush (1..15)
//  WDOG_LIMIT    1024  consecutive stalled cycles before o_wdogErr sets (>=2)
//  CNT_W         32    width of o_stallCycles
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-high
//  i_idStallReq   in   1       ID load-use hazard (level)
//  i_exStallReq   in   1       EX multi-cycle op busy (level)
//  i_memStallReq  in   1       MEM access not complete (level)
//  i_flushReq     in   1       flush request, 1-cycle pulse
//  i_flushPc      in   ADDR_W  redirect target, valid with i_flushReq
//  o_stall        out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage register
//  o_flush        out  1       clear IF/ID, ID/EX, EX/MEM registers
//  o_newPc        out  ADDR_W  PC load value, valid while o_flush=1
//  o_wdogErr      out  1       sticky: stall watchdog expired
//  o_stallCycles  out  CNT_W   saturating count of cycles with o_stall!=0
// BEHAVIOUR
//  Reset (async, rst=1): state=RUN, pending=0, o_flush=0, o_newPc=0, o_wdogErr=0,
//   o_stallCycles=0, watchdog=0; o_stall forced to 6'b000000.
//  o_stall: combinational, same cycle as requests; in RUN:
//   mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else 6'b000000.
//  FSM, all state/outputs registered except o_stall:
//   RUN: i_flushReq & !i_memStallReq -> FLUSH next cycle, latch i_flushPc into o_newPc, cnt=FLUSH_CYCLES.
//        i_flushReq & i_memStallReq -> latch target into pending slot, stay RUN.
//        pending & !i_memStallReq -> FLUSH next cycle, o_newPc<=pending target, pending cleared.
//   FLUSH: o_flush=1, o_stall=6'b000000 (ID/EX stall requests ignored; MEM stall still yields 6'b011111
//        and freezes cnt); cnt decrements each non-frozen cycle; cnt reaches 0 -> RUN, o_flush=0.
//        i_flushReq in FLUSH: restart, o_newPc<=new target, cnt=FLUSH_CYCLES.
//  Pending slot holds one request; a newer i_flushReq overwrites it (newest target wins).
//  Flush latency: request at edge N (memory idle) -> o_flush=1 from edge N+1 for FLUSH_CYCLES cycles.
//  Watchdog: counts consecutive cycles with o_stall!=0, clears on any o_stall==0 cycle;
//   reaching WDOG_LIMIT sets o_wdogErr, which holds until rst. Watchdog counter saturates.
//  o_stallCycles: +1 per cycle with o_stall!=0, saturates at all-ones, never wraps.
//  Reset mid-flush or with pending set: all state discarded, no flush emitted after reset.
// TESTING
//  1 rst pulse mid-FLUSH -> o_flush=0, o_newPc=0, o_stallCycles=0 immediately (async), RUN after release.
//  2 id=1,ex=1,mem=0 -> o_stall=6'b001111 same cycle; mem=1 added -> 6'b011111; all 0 -> 6'b000000.
//  3 flushReq, flushPc=32'h0000_0040, mem idle -> next cycle o_flush=1, o_newPc=32'h40, 1 cycle (FLUSH_CYCLES=1).
//  4 mem=1 for 3 cycles; flushReq pc=0x80 in cycle 1, pc=0x90 in cycle 2 -> no flush until mem=0,
//    then one flush with o_newPc=32'h90.
//  5 WDOG_LIMIT=8, ex=1 for 8 cycles -> o_wdogErr=1 after 8th; ex=0 -> stays 1; 7-cycle burst -> stays 0.
//  6 CNT_W=4, 20 stalled cycles -> o_stallCycles=4'hF and holds.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// Latency: o_stall is combinational from the requests. o_flush/o_newPc are valid
//   from the edge after an accepted flush request and are held FLUSH_CYCLES cycles.
// Backpressure: a MEM stall delays the start of a flush (the request is parked in a
//   one-deep pending slot, newest target wins) and freezes a flush already in progress.
// Ports:
//   clk, rst                        clock (rising edge), asynchronous active-high reset
//   i_idStallReq/i_exStallReq/
//   i_memStallReq                   level stall requests from ID, EX and MEM
//   i_flushReq, i_flushPc           one-cycle flush pulse and its redirect target
//   o_stall[5:0]                    per-stage hold vector {WB,MEM,EX,ID,IF,PC}
//   o_flush, o_newPc                pipeline-register clear and PC load value
//   o_wdogErr                       sticky stall watchdog expiry
//   o_stallCycles                   saturating count of cycles with any stage held
module pipeline_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 1024,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_idStallReq,
  input  logic              i_exStallReq,
  input  logic              i_memStallReq,
  input  logic              i_flushReq,
  input  logic [ADDR_W-1:0] i_flushPc,
  output logic [5:0]        o_stall,
  output logic              o_flush,
  output logic [ADDR_W-1:0] o_newPc,
  output logic              o_wdogErr,
  output logic [CNT_W-1:0]  o_stallCycles
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int              WD_W       = $clog2(WDOG_LIMIT + 1);
  localparam logic [3:0]      C_FLUSH    = 4'(FLUSH_CYCLES);
  localparam logic [WD_W-1:0] C_WD_LIMIT = WD_W'(WDOG_LIMIT);

  logic [0:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_pendVld;
  logic [ADDR_W-1:0] r_pendPc;
  logic              r_flush;
  logic [ADDR_W-1:0] r_newPc;
  logic              r_wdogErr;
  logic [WD_W-1:0]   r_wdog;
  logic [CNT_W-1:0]  r_stallCycles;
  logic              w_stalled;

  // MEM stalls hold everything up to MEM in both states; during a flush the
  // younger stages are being cleared anyway, so ID/EX requests are ignored.
  always_comb begin
    o_stall = 6'b000000;
    if (rst) begin
      o_stall = 6'b000000;
    end else if (i_memStallReq) begin
      o_stall = 6'b011111;
    end else if (r_state == ST_RUN) begin
      if (i_exStallReq)      o_stall = 6'b001111;
      else if (i_idStallReq) o_stall = 6'b000111;
    end
  end

  assign w_stalled = (o_stall != 6'b000000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= 4'd0;
      r_pendVld <= 1'b0;
      r_pendPc  <= '0;
      r_flush   <= 1'b0;
      r_newPc   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_flushReq && !i_memStallReq) begin
            // A fresh request supersedes anything parked in the pending slot.
            r_state   <= ST_FLUSH;
            r_flush   <= 1'b1;
            r_newPc   <= i_flushPc;
            r_cnt     <= C_FLUSH;
            r_pendVld <= 1'b0;
          end else if (i_flushReq) begin
            r_pendVld <= 1'b1;
            r_pendPc  <= i_flushPc;
          end else if (r_pendVld && !i_memStallReq) begin
            r_state   <= ST_FLUSH;
            r_flush   <= 1'b1;
            r_newPc   <= r_pendPc;
            r_cnt     <= C_FLUSH;
            r_pendVld <= 1'b0;
          end
        end
        default: begin
          if (i_flushReq) begin
            r_newPc <= i_flushPc;
            r_cnt   <= C_FLUSH;
          end else if (!i_memStallReq) begin
            // Count only cycles where the clear actually propagates.
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= ST_RUN;
              r_flush <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog        <= '0;
      r_wdogErr     <= 1'b0;
      r_stallCycles <= '0;
    end else begin
      if (w_stalled) begin
        if (r_wdog != C_WD_LIMIT) r_wdog <= r_wdog + 1'b1;
        // This cycle is the WDOG_LIMIT-th consecutive stalled one.
        if (r_wdog >= C_WD_LIMIT - WD_W'(1)) r_wdogErr <= 1'b1;
        if (r_stallCycles != {CNT_W{1'b1}}) r_stallCycles <= r_stallCycles + 1'b1;
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign o_flush       = r_flush;
  assign o_newPc       = r_newPc;
  assign o_wdogErr     = r_wdogErr;
  assign o_stallCycles = r_stallCycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id = 1'b0, ex = 1'b0, mem = 1'b0, fr = 1'b0;
  logic [31:0] pc = 32'h0;

  always #5 clk = ~clk;

  // Instance A: FLUSH_CYCLES=1, WDOG_LIMIT=8, CNT_W=4
  logic [5:0]  a_stall;
  logic        a_flush, a_err;
  logic [31:0] a_npc;
  logic [3:0]  a_cnt;
  // Instance B: FLUSH_CYCLES=3, WDOG_LIMIT=20, CNT_W=8
  logic [5:0]  b_stall;
  logic        b_flush, b_err;
  logic [31:0] b_npc;
  logic [7:0]  b_cnt;

  pipeline_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1), .WDOG_LIMIT(8), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .i_idStallReq(id), .i_exStallReq(ex), .i_memStallReq(mem),
    .i_flushReq(fr), .i_flushPc(pc), .o_stall(a_stall), .o_flush(a_flush),
    .o_newPc(a_npc), .o_wdogErr(a_err), .o_stallCycles(a_cnt));

  pipeline_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(3), .WDOG_LIMIT(20), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .i_idStallReq(id), .i_exStallReq(ex), .i_memStallReq(mem),
    .i_flushReq(fr), .i_flushPc(pc), .o_stall(b_stall), .o_flush(b_flush),
    .o_newPc(b_npc), .o_wdogErr(b_err), .o_stallCycles(b_cnt));

  int nvec = 0;
  int nerr = 0;

  // Reference model: flush cycles still owed, pending request, sticky flags, counts.
  int          fcs [2]  = '{1, 3};
  int          wls [2]  = '{8, 20};
  int          cmax [2] = '{15, 255};
  int          m_left [2];
  bit          m_pv [2];
  logic [31:0] m_ppc [2];
  logic [31:0] m_npc [2];
  int          m_wd [2];
  bit          m_err [2];
  int          m_cnt [2];

  function automatic logic [5:0] dut_stall(int k); return k ? b_stall : a_stall; endfunction
  function automatic logic       dut_flush(int k); return k ? b_flush : a_flush; endfunction
  function automatic logic [31:0] dut_npc(int k);  return k ? b_npc : a_npc;     endfunction
  function automatic logic       dut_err(int k);   return k ? b_err : a_err;     endfunction
  function automatic int         dut_cnt(int k);   return k ? int'(b_cnt) : int'(a_cnt); endfunction

  function automatic logic [5:0] exp_stall(int k);
    if (mem)           return 6'b011111;
    if (m_left[k] > 0) return 6'b000000;
    if (ex)            return 6'b001111;
    if (id)            return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_pv[k] = 0; m_ppc[k] = 0; m_npc[k] = 0;
      m_wd[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic m_update(int k);
    bit st;
    st = (exp_stall(k) != 6'b000000);
    if (m_left[k] > 0) begin
      if (fr) begin m_left[k] = fcs[k]; m_npc[k] = pc; end
      else if (!mem) m_left[k] = m_left[k] - 1;
    end else if (fr && !mem) begin
      m_left[k] = fcs[k]; m_npc[k] = pc; m_pv[k] = 0;
    end else if (fr) begin
      m_pv[k] = 1; m_ppc[k] = pc;
    end else if (m_pv[k] && !mem) begin
      m_left[k] = fcs[k]; m_npc[k] = m_ppc[k]; m_pv[k] = 0;
    end
    if (st) begin
      m_wd[k] = m_wd[k] + 1;
      if (m_wd[k] >= wls[k]) begin m_err[k] = 1; m_wd[k] = wls[k]; end
      m_cnt[k] = (m_cnt[k] + 1 > cmax[k]) ? cmax[k] : m_cnt[k] + 1;
    end else begin
      m_wd[k] = 0;
    end
  endtask

  task automatic apply(input bit i_id, input bit i_ex, input bit i_mem, input bit i_fr,
                       input logic [31:0] i_pc);
    id = i_id; ex = i_ex; mem = i_mem; fr = i_fr; pc = i_pc;
    #1;
  endtask

  task automatic clk_step();
    for (int k = 0; k < 2; k++) m_update(k);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    apply(0, 0, 1, 0, 32'h0);
    m_reset();
    for (int k = 0; k < 2; k++) begin
      nvec++; if (dut_stall(k) !== 6'b000000) begin nerr++; $display("FAIL reset_stall[%0d]: got %b want 000000", k, dut_stall(k)); end
      nvec++; if (dut_flush(k) !== 1'b0) begin nerr++; $display("FAIL reset_flush[%0d]: got %b want 0", k, dut_flush(k)); end
      nvec++; if (dut_npc(k) !== 32'h0) begin nerr++; $display("FAIL reset_newpc[%0d]: got %h want 0", k, dut_npc(k)); end
      nvec++; if (dut_err(k) !== 1'b0) begin nerr++; $display("FAIL reset_wdog[%0d]: got %b want 0", k, dut_err(k)); end
      nvec++; if (dut_cnt(k) != 0) begin nerr++; $display("FAIL reset_cnt[%0d]: got %0d want 0", k, dut_cnt(k)); end
    end
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_stall_merge();
    apply(1, 1, 0, 0, 32'h0);
    nvec++; if (a_stall !== 6'b001111) begin nerr++; $display("FAIL merge_id_ex: got %b want 001111", a_stall); end
    apply(1, 1, 1, 0, 32'h0);
    nvec++; if (a_stall !== 6'b011111) begin nerr++; $display("FAIL merge_mem: got %b want 011111", a_stall); end
    apply(1, 0, 0, 0, 32'h0);
    nvec++; if (b_stall !== 6'b000111) begin nerr++; $display("FAIL merge_id: got %b want 000111", b_stall); end
    apply(0, 0, 0, 0, 32'h0);
    nvec++; if (a_stall !== 6'b000000) begin nerr++; $display("FAIL merge_none: got %b want 000000", a_stall); end
    clk_step();
  endtask

  task automatic test_flush_basic();
    logic exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_a [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    apply(0, 0, 0, 1, 32'h0000_0040);
    clk_step();
    apply(1, 1, 0, 0, 32'h0);
    nvec++; if (a_stall !== 6'b000000) begin nerr++; $display("FAIL flush_ignores_ex: got %b want 000000", a_stall); end
    nvec++; if (a_npc !== 32'h40) begin nerr++; $display("FAIL flush_newpc: got %h want 00000040", a_npc); end
    apply(0, 0, 0, 0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      nvec++; if (a_flush !== exp_a[c]) begin nerr++; $display("FAIL flush_a_len c%0d: got %b want %b", c, a_flush, exp_a[c]); end
      nvec++; if (b_flush !== exp_b[c]) begin nerr++; $display("FAIL flush_b_len c%0d: got %b want %b", c, b_flush, exp_b[c]); end
      clk_step();
    end
  endtask

  task automatic test_pending();
    apply(0, 0, 1, 1, 32'h0000_0080); clk_step();
    apply(0, 0, 1, 1, 32'h0000_0090); clk_step();
    nvec++; if (a_flush !== 1'b0) begin nerr++; $display("FAIL pend_hold1: got %b want 0", a_flush); end
    apply(0, 0, 1, 0, 32'h0); clk_step();
    nvec++; if (b_flush !== 1'b0) begin nerr++; $display("FAIL pend_hold2: got %b want 0", b_flush); end
    apply(0, 0, 0, 0, 32'h0); clk_step();
    nvec++; if (a_flush !== 1'b1) begin nerr++; $display("FAIL pend_fire: got %b want 1", a_flush); end
    nvec++; if (a_npc !== 32'h90) begin nerr++; $display("FAIL pend_newest: got %h want 00000090", a_npc); end
    nvec++; if (b_npc !== 32'h90) begin nerr++; $display("FAIL pend_newest_b: got %h want 00000090", b_npc); end
    clk_step();
    nvec++; if (a_flush !== 1'b0) begin nerr++; $display("FAIL pend_single: got %b want 0", a_flush); end
    for (int c = 0; c < 3; c++) clk_step();
  endtask

  task automatic test_flush_freeze();
    bit ms [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    apply(0, 0, 0, 1, 32'h0000_0100); clk_step();
    for (int c = 0; c < 6; c++) begin
      apply(0, 0, ms[c], 0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        nvec++; if (dut_flush(k) !== (m_left[k] > 0)) begin nerr++; $display("FAIL freeze[%0d] c%0d: got %b want %b", k, c, dut_flush(k), m_left[k] > 0); end
      end
      clk_step();
    end
  endtask

  task automatic test_wdog();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      apply(0, 1, 0, 0, 32'h0); clk_step();
      if (c == 6) begin
        nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL wdog_7: got %b want 0", a_err); end
      end
    end
    nvec++; if (a_err !== 1'b1) begin nerr++; $display("FAIL wdog_8: got %b want 1", a_err); end
    apply(0, 0, 0, 0, 32'h0); clk_step();
    nvec++; if (a_err !== 1'b1) begin nerr++; $display("FAIL wdog_sticky: got %b want 1", a_err); end
    do_reset();
    for (int c = 0; c < 7; c++) begin apply(0, 1, 0, 0, 32'h0); clk_step(); end
    apply(0, 0, 0, 0, 32'h0); clk_step();
    for (int c = 0; c < 7; c++) begin apply(0, 1, 0, 0, 32'h0); clk_step(); end
    nvec++; if (a_err !== 1'b0) begin nerr++; $display("FAIL wdog_burst7: got %b want 0", a_err); end
    apply(0, 0, 0, 0, 32'h0); clk_step();
  endtask

  task automatic test_stall_sat();
    do_reset();
    for (int c = 0; c < 20; c++) begin apply(0, 0, 1, 0, 32'h0); clk_step(); end
    nvec++; if (a_cnt !== 4'hF) begin nerr++; $display("FAIL cnt_sat: got %h want f", a_cnt); end
    nvec++; if (b_cnt !== 8'd20) begin nerr++; $display("FAIL cnt_b20: got %0d want 20", b_cnt); end
    nvec++; if (b_err !== 1'b1) begin nerr++; $display("FAIL wdog_b20: got %b want 1", b_err); end
    apply(0, 0, 1, 0, 32'h0); clk_step();
    apply(0, 0, 0, 0, 32'h0); clk_step();
    nvec++; if (a_cnt !== 4'hF) begin nerr++; $display("FAIL cnt_hold: got %h want f", a_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    apply(0, 1, 0, 0, 32'h0); clk_step();
    apply(0, 0, 0, 1, 32'h0000_0200); clk_step();
    apply(0, 0, 1, 0, 32'h0);
    #1 rst = 1'b1;
    #1;
    nvec++; if (b_flush !== 1'b0) begin nerr++; $display("FAIL rstmid_flush: got %b want 0", b_flush); end
    nvec++; if (b_npc !== 32'h0) begin nerr++; $display("FAIL rstmid_newpc: got %h want 0", b_npc); end
    nvec++; if (a_cnt !== 4'h0) begin nerr++; $display("FAIL rstmid_cnt: got %h want 0", a_cnt); end
    nvec++; if (a_stall !== 6'b000000) begin nerr++; $display("FAIL rstmid_stall: got %b want 000000", a_stall); end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    // Park a request, reset again: it must never fire.
    apply(0, 0, 1, 1, 32'h0000_0300); clk_step();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(0, 0, 0, 0, 32'h0); clk_step();
      nvec++; if (a_flush !== 1'b0) begin nerr++; $display("FAIL rstpend c%0d: got %b want 0", c, a_flush); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 6) == 0, $urandom);
      for (int k = 0; k < 2; k++) begin
        nvec++; if (dut_stall(k) !== exp_stall(k)) begin nerr++; $display("FAIL rnd_stall[%0d] c%0d: got %b want %b", k, c, dut_stall(k), exp_stall(k)); end
      end
      clk_step();
      for (int k = 0; k < 2; k++) begin
        nvec++; if (dut_flush(k) !== (m_left[k] > 0)) begin nerr++; $display("FAIL rnd_flush[%0d] c%0d: got %b want %b", k, c, dut_flush(k), m_left[k] > 0); end
        if (m_left[k] > 0) begin
          nvec++; if (dut_npc(k) !== m_npc[k]) begin nerr++; $display("FAIL rnd_newpc[%0d] c%0d: got %h want %h", k, c, dut_npc(k), m_npc[k]); end
        end
        nvec++; if (dut_err(k) !== m_err[k]) begin nerr++; $display("FAIL rnd_wdog[%0d] c%0d: got %b want %b", k, c, dut_err(k), m_err[k]); end
        nvec++; if (dut_cnt(k) != m_cnt[k]) begin nerr++; $display("FAIL rnd_cnt[%0d] c%0d: got %0d want %0d", k, c, dut_cnt(k), m_cnt[k]); end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    @(negedge clk);
    test_stall_merge();
    test_flush_basic();
    test_pending();
    test_flush_freeze();
    test_wdog();
    test_stall_sat();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
